// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - frame sequencer between UART RX FIFO, ALU and UART TX FIFO
//
// Pops operand A, operand B and opcode from the RX FIFO, holds them stable
// for the combinational ALU, captures the result, and pushes it into the TX FIFO.
// A per-byte watchdog in GET_B/GET_OP drops incomplete frames so that a lost
// byte cannot shift the operand/opcode order of the following frames.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rx_empty, rx_r_data     RX FIFO status and head word
//   rx_rd                   RX FIFO pop strobe (combinational)
//   tx_full                 TX FIFO full flag
//   tx_wr, tx_w_data        TX FIFO push strobe (combinational) and data
//   alu_a, alu_b, alu_op    registered ALU operands and opcode
//   alu_result              combinational ALU result
//   busy                    high whenever a frame is in progress
//   frame_cnt               completed frames, wrapping
//   err_cnt                 aborted frames, saturating
//   timeout                 one-cycle pulse on frame abort
module uart_alu_sequencer #(
    parameter int DBIT      = 8,
    parameter int OPW       = 6,
    parameter int TO_CYCLES = 50000,
    parameter int TO_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] rx_r_data,
    output logic            rx_rd,
    input  logic            tx_full,
    output logic            tx_wr,
    output logic [DBIT-1:0] tx_w_data,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [DBIT-1:0] alu_result,
    output logic            busy,
    output logic [7:0]      frame_cnt,
    output logic [7:0]      err_cnt,
    output logic            timeout
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        PUT    = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] to_cnt;
    logic            watch;

    always_comb begin
        state_next = state;
        rx_rd      = 1'b0;
        tx_wr      = 1'b0;
        timeout    = 1'b0;
        watch      = 1'b0;
        case (state)
            GET_A: begin
                // Gated with reset so the pop strobe reads 0 while reset is held,
                // even though GET_A would otherwise pop a waiting byte.
                rx_rd = rst_n && !rx_empty;
                if (rx_rd) state_next = GET_B;
            end
            GET_B, GET_OP: begin
                watch = 1'b1;
                rx_rd = rst_n && !rx_empty;
                if (rx_rd) begin
                    state_next = (state == GET_B) ? GET_OP : EXEC;
                end else if (to_cnt == TO_LAST) begin
                    // An arriving byte takes priority over the abort.
                    state_next = GET_A;
                    timeout    = 1'b1;
                end
            end
            EXEC: begin
                state_next = PUT;
            end
            PUT: begin
                tx_wr = !tx_full;
                if (tx_wr) state_next = GET_A;
            end
            default: begin
                state_next = GET_A;
            end
        endcase
    end

    assign busy = (state != GET_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            tx_w_data <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            if (rx_rd) begin
                case (state)
                    GET_A:   alu_a  <= rx_r_data;
                    GET_B:   alu_b  <= rx_r_data;
                    GET_OP:  alu_op <= rx_r_data[OPW-1:0];
                    default: ;
                endcase
            end
            if (state == EXEC) tx_w_data <= alu_result;
            if (tx_wr) frame_cnt <= frame_cnt + 8'd1;
            if (timeout && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            // Counts empty cycles since the last pop; any pop, abort or
            // leaving the watched states returns it to zero.
            if (watch && rx_empty && !timeout) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb/tb_uart_alu_sequencer.sv - directed self-checking bench for uart_alu_sequencer
module tb_uart_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       rx_empty;
    logic [7:0] rx_r_data;
    logic       rx_rd;
    logic       tx_full;
    logic       tx_wr;
    logic [7:0] tx_w_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [256];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;

    uart_alu_sequencer #(
        .DBIT(8), .OPW(6), .TO_CYCLES(8), .TO_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_empty(rx_empty), .rx_r_data(rx_r_data), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_w_data(tx_w_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // RX FIFO model
    assign rx_empty  = (rd_ptr == wr_ptr);
    assign rx_r_data = mem[rd_ptr];
    always @(posedge clk) if (rx_rd) rd_ptr <= rd_ptr + 8'd1;

    // ALU model: 0x20 add, 0x22 subtract, anything else xor
    assign alu_result = (alu_op == 6'h20) ? alu_a + alu_b :
                        (alu_op == 6'h22) ? alu_a - alu_b : alu_a ^ alu_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        push(a); push(b); push(op);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        tx_full = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rx_rd", rx_rd, 0);
        check("rst_tx_wr", tx_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_alu", {alu_a, alu_b, 2'b00, alu_op}, 0);
        check("rst_tx_w_data", tx_w_data, 0);
        rst_n = 1'b1;

        // Single frame: 5 + 3 = 8
        push(8'h05); push(8'h03); push(8'h20);
        #1;
        check("f1_rd_c1", rx_rd, 1);
        @(negedge clk);
        check("f1_rd_c2", rx_rd, 1);
        check("f1_busy", busy, 1);
        @(negedge clk);
        check("f1_rd_c3", rx_rd, 1);
        @(negedge clk);
        check("f1_exec_rd", rx_rd, 0);
        check("f1_exec_wr", tx_wr, 0);
        check("f1_alu_a", alu_a, 8'h05);
        check("f1_alu_b", alu_b, 8'h03);
        check("f1_alu_op", alu_op, 6'h20);
        @(negedge clk);
        check("f1_put_wr", tx_wr, 1);
        check("f1_put_rd", rx_rd, 0);
        check("f1_put_data", tx_w_data, 8'h08);
        @(negedge clk);
        check("f1_frame_cnt", frame_cnt, 1);
        check("f1_idle_busy", busy, 0);
        check("f1_idle_wr", tx_wr, 0);

        // TX backpressure: 0x10 - 0x07 = 0x09
        tx_full = 1'b1;
        push(8'h10); push(8'h07); push(8'h22);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp_wr_held", tx_wr, 0);
            check("bp_busy", busy, 1);
            check("bp_timeout", timeout, 0);
            @(negedge clk);
        end
        check("bp_data_held", tx_w_data, 8'h09);
        tx_full = 1'b0;
        #1;
        check("bp_wr_release", tx_wr, 1);
        @(negedge clk);
        check("bp_frame_cnt", frame_cnt, 2);
        check("bp_idle", busy, 0);

        // Inter-byte timeout after the second byte
        push(8'h11); push(8'h22);
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            check("to_pulse", timeout, (i == 8));
            check("to_busy", busy, 1);
            @(negedge clk);
        end
        check("to_state_idle", busy, 0);
        check("to_pulse_gone", timeout, 0);
        check("to_err_cnt", err_cnt, 1);
        check("to_stale_a", alu_a, 8'h11);
        check("to_stale_b", alu_b, 8'h22);
        push(8'h01); push(8'h02); push(8'h20);
        repeat (4) @(negedge clk);
        check("to_recover_wr", tx_wr, 1);
        check("to_recover_data", tx_w_data, 8'h03);
        @(negedge clk);
        check("to_recover_cnt", frame_cnt, 3);

        // Timeout race: byte arrives on the last watchdog cycle
        push(8'h30); push(8'h40);
        repeat (2) @(negedge clk);
        repeat (7) @(negedge clk);
        check("race_pre_fire", timeout, 1);
        push(8'h20);
        #1;
        check("race_no_timeout", timeout, 0);
        check("race_pop", rx_rd, 1);
        @(negedge clk);
        check("race_exec_busy", busy, 1);
        check("race_err_cnt", err_cnt, 1);
        @(negedge clk);
        check("race_wr", tx_wr, 1);
        check("race_data", tx_w_data, 8'h70);
        @(negedge clk);
        check("race_frame_cnt", frame_cnt, 4);

        // frame_cnt wrap: 252 more frames bring the total to 256
        for (int i = 0; i < 252; i++) begin
            do_frame(8'(i), 8'h01, 8'h20);
            if (i == 250) check("wrap_255", frame_cnt, 8'hFF);
        end
        check("wrap_0", frame_cnt, 0);
        check("wrap_last_data", tx_w_data, 8'hFC);

        // err_cnt saturation: 300 aborts on top of 1
        for (int i = 0; i < 300; i++) begin
            push(8'hAA);
            repeat (9) @(negedge clk);
            if (i == 252) check("sat_254", err_cnt, 8'hFE);
        end
        check("sat_255", err_cnt, 8'hFF);
        check("sat_idle", busy, 0);

        // Reset mid-frame, asserted off the clock edge
        push(8'h55);
        @(negedge clk);
        check("mr_a_popped", alu_a, 8'h55);
        check("mr_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mr_alu_a", alu_a, 0);
        check("mr_busy_clr", busy, 0);
        check("mr_frame_cnt", frame_cnt, 0);
        check("mr_err_cnt", err_cnt, 0);
        check("mr_tx_w_data", tx_w_data, 0);
        check("mr_tx_wr", tx_wr, 0);
        push(8'h09); push(8'h04); push(8'h20);
        #1;
        check("mr_rd_in_reset", rx_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_rd_after", rx_rd, 1);
        repeat (3) @(negedge clk);
        check("mr_alu_a_new", alu_a, 8'h09);
        check("mr_alu_b_new", alu_b, 8'h04);
        @(negedge clk);
        check("mr_wr", tx_wr, 1);
        check("mr_data", tx_w_data, 8'h0D);
        @(negedge clk);
        check("mr_frame_cnt_new", frame_cnt, 1);
        check("mr_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
